sram_responder: RTL and testbench
=================================

Name: sram_responder

Overview:
- Cycle-accurate responder for the external SRAM port driven by the team's SRAM controller (17-bit word address, 32-bit bidirectional data, active-low strobes).
- Holds a word array and enforces programmable read-access and write-pulse latencies.
- Returns read data on the shared DQ bus and flags protocol violations.
- Used as the SRAM stand-in for system simulation, and as an on-chip SRAM emulator on boards without the device.

Parameters:
- DATA_W, 32, data bus width.
- ADDR_W, 17, SRAM_ADDR port width.
- MEM_AW, 16, index bits actually stored; DEPTH = 2**MEM_AW words; index = SRAM_ADDR[MEM_AW-1:0] (upper bits ignored, wrap-around).
- READ_LAT, 2, cycles of stable read address before data is driven; legal range >=1.
- WRITE_LAT, 2, cycles WE_N must be held low at a stable address before the write commits; legal range >=1.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset; synchronous, active-low (rst==0 at a rising edge resets).
- SRAM_ADDR  in  ADDR_W  word address from the controller.
- SRAM_WE_N  in  1  write enable, active-low.
- SRAM_CE_N  in  1  chip enable, active-low.
- SRAM_OE_N  in  1  output enable, active-low.
- SRAM_DQ  inout  DATA_W  shared data bus.
- rd_valid  out  1  high while read data is being presented (state RD_DRIVE).
- wr_commit  out  1  one-cycle pulse on the cycle after a write lands in the array.
- viol  out  1  sticky protocol-violation flag.

Behaviour:
- Reset: state IDLE, cnt=0, addr_q=0, rdata_q=0, rd_valid=0, wr_commit=0, viol=0, DQ=Z. Memory contents are not cleared.
- Reset mid-operation: a pending write is dropped, and DQ releases to Z on the same edge.
- FSM states: IDLE, RD_WAIT, RD_DRIVE, WR_WAIT, WR_DONE.
- CE_N==1 at any edge forces the next state to IDLE, cnt=0, with no write or violation. CE_N has the highest priority after reset.
- IDLE:
  - WE_N==0 -> WR_WAIT, addr_q<=SRAM_ADDR, cnt<=1.
  - else -> RD_WAIT, addr_q<=SRAM_ADDR, cnt<=1.
- RD_WAIT:
  - WE_N==0 -> WR_WAIT, cnt<=1 (read abandoned, no violation).
  - SRAM_ADDR!=addr_q -> addr_q<=SRAM_ADDR, cnt<=1 (restart).
  - cnt==READ_LAT -> RD_DRIVE, rdata_q<=mem[addr_q].
  - else cnt<=cnt+1.
  - Latency: with the address applied before edge 0, data is valid on DQ after edge READ_LAT.
- RD_DRIVE:
  - rd_valid=1.
  - Address change -> RD_WAIT, cnt<=1.
  - WE_N==0 -> WR_WAIT, cnt<=1.
  - else hold.
- WR_WAIT:
  - Address change or WE_N==1 before commit -> viol<=1, write discarded. Next state is RD_WAIT (WE_N high) or WR_WAIT restarted with cnt<=1 (new address, WE_N low).
  - cnt==WRITE_LAT -> mem[addr_q]<=SRAM_DQ sampled at this edge; wr_commit<=1 for one cycle; -> WR_DONE.
  - else cnt<=cnt+1.
- WR_DONE: the array is not rewritten while WE_N stays low. WE_N==1 -> RD_WAIT, cnt<=1, addr_q<=SRAM_ADDR. Address change with WE_N low -> WR_WAIT, cnt<=1.
- DQ drive (combinational): DQ = rdata_q only when state==RD_DRIVE && OE_N==0 && WE_N==1 && CE_N==0; otherwise Z. A WE_N falling edge therefore releases the bus the same cycle, with no contention window.
- cnt width is clog2(max(READ_LAT,WRITE_LAT))+1; cnt saturates and never wraps.
- viol is cleared only by reset.

Test Plan:
- Write then read:
  - Stimulus: addr=0x00100, DQ=0xA5A5_1234, WE_N low 3 cycles, then WE_N high, OE_N low.
  - Response: wr_commit pulses exactly once, 2 edges after WE_N falls; rd_valid rises 2 edges after WE_N rises; DQ=0xA5A5_1234.
- Short write pulse:
  - Stimulus: WE_N low for 1 cycle at addr 0x00200 (prior content 0x0).
  - Response: viol=1, no wr_commit, subsequent read of 0x00200 returns 0x0000_0000.
- Address change mid-read:
  - Stimulus: addr=0x10 for 1 cycle, then 0x11.
  - Response: latency restarts; DQ shows mem[0x11] 2 edges after the change and never mem[0x10].
- Bus release:
  - Stimulus: in RD_DRIVE, drop OE_N high, then WE_N low.
  - Response: DQ=Z in the same cycle each time; a bench driver writing DQ sees no X.
- Wrap and CE:
  - Stimulus: write 0xDEAD_BEEF to addr 0x1_0005 with MEM_AW=16; read addr 0x0_0005.
  - Response: returns 0xDEAD_BEEF.
  - Stimulus: raise CE_N during WR_WAIT.
  - Response: no write, no viol.
- Reset mid-write:
  - Stimulus: rst=0 during WR_WAIT cycle 1.
  - Response: next cycle IDLE, all outputs 0, DQ=Z, target word unchanged.

Source files
------------

// File: rtl/sram_responder_if.sv
// Controller-side SRAM address and strobe bundle. DQ is kept as a plain inout port on the
// responder so that tri-state resolution stays at module boundaries.
interface sram_responder_if #(
    parameter int unsigned ADDR_W = 17
) ();
    logic [ADDR_W-1:0] SRAM_ADDR;
    logic              SRAM_WE_N;
    logic              SRAM_CE_N;
    logic              SRAM_OE_N;

    modport master (
        output SRAM_ADDR,
        output SRAM_WE_N,
        output SRAM_CE_N,
        output SRAM_OE_N
    );

    modport slave (
        input SRAM_ADDR,
        input SRAM_WE_N,
        input SRAM_CE_N,
        input SRAM_OE_N
    );
endinterface

// File: rtl/sram_responder.sv
// Cycle-accurate external SRAM responder with programmable read-access and write-pulse latency.
// It drives read data onto the shared DQ bus and raises a sticky flag on protocol violations.
module sram_responder #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned MEM_AW    = 16,
    parameter int unsigned READ_LAT  = 2,
    parameter int unsigned WRITE_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    sram_responder_if.slave   bus,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic              rd_valid,
    output logic              wr_commit,
    output logic              viol
);

    localparam int unsigned DEPTH   = 2 ** MEM_AW;
    localparam int unsigned MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;
    localparam logic [CNT_W-1:0] RD_CNT  = CNT_W'(READ_LAT);
    localparam logic [CNT_W-1:0] WR_CNT  = CNT_W'(WRITE_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        StIdle,
        StRdWait,
        StRdDrive,
        StWrWait,
        StWrDone
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rd_valid_q, rd_valid_d;
    logic                wr_commit_q, wr_commit_d;
    logic                viol_q, viol_d;
    logic                mem_we;
    logic                addr_chg;
    logic                dq_oe;

    logic [DATA_W-1:0]   mem [DEPTH];

    assign addr_chg = (bus.SRAM_ADDR != addr_q);
    assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        viol_d  = viol_q;
        mem_we  = 1'b0;

        if (bus.SRAM_CE_N) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    addr_d  = bus.SRAM_ADDR;
                    cnt_d   = CNT_ONE;
                    state_d = bus.SRAM_WE_N ? StRdWait : StWrWait;
                end
                StRdWait: begin
                    if (!bus.SRAM_WE_N) begin
                        state_d = StWrWait;
                        addr_d  = bus.SRAM_ADDR;
                        cnt_d   = CNT_ONE;
                    end else if (addr_chg) begin
                        addr_d = bus.SRAM_ADDR;
                        cnt_d  = CNT_ONE;
                    end else if (cnt_q == RD_CNT) begin
                        state_d = StRdDrive;
                        rdata_d = mem[addr_q[MEM_AW-1:0]];
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StRdDrive: begin
                    if (addr_chg) begin
                        state_d = StRdWait;
                        addr_d  = bus.SRAM_ADDR;
                        cnt_d   = CNT_ONE;
                    end else if (!bus.SRAM_WE_N) begin
                        state_d = StWrWait;
                        cnt_d   = CNT_ONE;
                    end
                end
                StWrWait: begin
                    // A write pulse cut short or moved discards the write entirely.
                    if (bus.SRAM_WE_N || addr_chg) begin
                        viol_d  = 1'b1;
                        addr_d  = bus.SRAM_ADDR;
                        cnt_d   = CNT_ONE;
                        state_d = bus.SRAM_WE_N ? StRdWait : StWrWait;
                    end else if (cnt_q == WR_CNT) begin
                        mem_we  = 1'b1;
                        state_d = StWrDone;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StWrDone: begin
                    if (bus.SRAM_WE_N) begin
                        state_d = StRdWait;
                        addr_d  = bus.SRAM_ADDR;
                        cnt_d   = CNT_ONE;
                    end else if (addr_chg) begin
                        state_d = StWrWait;
                        addr_d  = bus.SRAM_ADDR;
                        cnt_d   = CNT_ONE;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end

        wr_commit_d = mem_we;
        rd_valid_d  = (state_d == StRdDrive);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            rdata_q     <= '0;
            rd_valid_q  <= 1'b0;
            wr_commit_q <= 1'b0;
            viol_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            rdata_q     <= rdata_d;
            rd_valid_q  <= rd_valid_d;
            wr_commit_q <= wr_commit_d;
            viol_q      <= viol_d;
        end
    end

    // Array has no reset; a reset edge only suppresses a commit landing on it.
    always_ff @(posedge clk) begin
        if (mem_we && rst) begin
            mem[addr_q[MEM_AW-1:0]] <= SRAM_DQ;
        end
    end

    assign dq_oe   = (state_q == StRdDrive) && !bus.SRAM_OE_N && bus.SRAM_WE_N && !bus.SRAM_CE_N;
    assign SRAM_DQ = dq_oe ? rdata_q : {DATA_W{1'bz}};

    assign rd_valid  = rd_valid_q;
    assign wr_commit = wr_commit_q;
    assign viol      = viol_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: expected read data is queued when a read is issued and
// compared when rd_valid rises; strobe timing, bus release, CE, wrap and reset are checked inline.
module tb_sram_responder;

    localparam logic [31:0] PAT = 32'h5A5A_C3C3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_valid, wr_commit, viol;
    logic [31:0] tb_dq;
    logic        tb_drv;
    wire  [31:0] dq;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] sb[$];

    sram_responder_if #(.ADDR_W(17)) bus ();

    assign dq = tb_drv ? tb_dq : 32'hzzzz_zzzz;

    sram_responder #(
        .DATA_W   (32),
        .ADDR_W   (17),
        .MEM_AW   (16),
        .READ_LAT (2),
        .WRITE_LAT(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .SRAM_DQ  (dq),
        .rd_valid (rd_valid),
        .wr_commit(wr_commit),
        .viol     (viol)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Full-length write; waits (bounded) for the commit pulse and leaves WE_N low in WR_DONE.
    task automatic write_word(input logic [16:0] a, input logic [31:0] d, input string tag);
        int n;
        bus.SRAM_ADDR = a;
        bus.SRAM_WE_N = 1'b0;
        bus.SRAM_OE_N = 1'b1;
        tb_drv        = 1'b1;
        tb_dq         = d;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!wr_commit && n < 8);
        chk({tag, "_commit"}, wr_commit, 1);
        tick(1);
        chk({tag, "_pulse"}, wr_commit, 0);
    endtask

    task automatic start_read(input logic [16:0] a, input logic [31:0] d);
        bus.SRAM_ADDR = a;
        bus.SRAM_WE_N = 1'b1;
        bus.SRAM_OE_N = 1'b0;
        tb_drv        = 1'b0;
        sb.push_back(d);
    endtask

    task automatic wait_read(input string tag, input int n_exp);
        int          n;
        logic [31:0] e;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!rd_valid && n < 8);
        chk({tag, "_lat"}, n, n_exp);
        chk({tag, "_sb"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_data"}, dq, e);
        end
    endtask

    initial begin
        tb_drv        = 1'b0;
        tb_dq         = '0;
        bus.SRAM_ADDR = '0;
        bus.SRAM_WE_N = 1'b1;
        bus.SRAM_CE_N = 1'b1;
        bus.SRAM_OE_N = 1'b1;
        tick(3);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wr_commit", wr_commit, 0);
        chk("rst_viol", viol, 0);
        tb_drv = 1'b1;
        tb_dq  = PAT;
        #1;
        chk("rst_dq_free", dq, PAT);

        // Write then read with exact strobe timing
        rst           = 1'b1;
        bus.SRAM_CE_N = 1'b0;
        bus.SRAM_WE_N = 1'b0;
        bus.SRAM_ADDR = 17'h0_0100;
        tb_dq         = 32'hA5A5_1234;
        tick(1);
        chk("wr_e0", wr_commit, 0);
        tick(1);
        chk("wr_e1", wr_commit, 0);
        tick(1);
        chk("wr_e2", wr_commit, 1);
        start_read(17'h0_0100, 32'hA5A5_1234);
        tick(1);
        chk("wr_once", wr_commit, 0);
        chk("rd_e0", rd_valid, 0);
        wait_read("wr_rd", 2);

        // Upper address bit is dropped by the array index
        write_word(17'h1_0005, 32'hDEAD_BEEF, "wrap_wr");
        start_read(17'h0_0005, 32'hDEAD_BEEF);
        wait_read("wrap_rd", 3);

        // CE_N high during WR_WAIT aborts silently
        write_word(17'h0_0300, 32'h1234_5678, "ce_pre");
        bus.SRAM_WE_N = 1'b1;
        tick(1);
        tb_dq         = 32'hFFFF_0000;
        bus.SRAM_WE_N = 1'b0;
        tick(1);
        bus.SRAM_CE_N = 1'b1;
        tick(1);
        chk("ce_no_commit0", wr_commit, 0);
        tick(2);
        chk("ce_no_commit1", wr_commit, 0);
        chk("ce_no_viol", viol, 0);
        bus.SRAM_CE_N = 1'b0;
        start_read(17'h0_0300, 32'h1234_5678);
        wait_read("ce_rd", 3);

        // Address change mid-read restarts latency
        write_word(17'h0_0010, 32'h1010_1010, "chg_w10");
        write_word(17'h0_0011, 32'h1111_1111, "chg_w11");
        bus.SRAM_ADDR = 17'h0_0010;
        bus.SRAM_WE_N = 1'b1;
        bus.SRAM_OE_N = 1'b0;
        tb_drv        = 1'b0;
        tick(1);
        chk("chg_e0", rd_valid, 0);
        start_read(17'h0_0011, 32'h1111_1111);
        wait_read("chg_rd", 3);

        // Bus release is combinational on OE_N and WE_N
        bus.SRAM_OE_N = 1'b1;
        tb_drv        = 1'b1;
        tb_dq         = PAT;
        #1;
        chk("rel_oe", dq, PAT);
        chk("rel_oe_valid", rd_valid, 1);
        tb_drv        = 1'b0;
        bus.SRAM_OE_N = 1'b0;
        #1;
        chk("rel_redrive", dq, 32'h1111_1111);
        bus.SRAM_WE_N = 1'b0;
        tb_drv        = 1'b1;
        #1;
        chk("rel_we", dq, PAT);
        bus.SRAM_WE_N = 1'b1;
        tb_drv        = 1'b0;
        #1;

        // Short write pulse flags a violation and leaves the word untouched
        write_word(17'h0_0200, 32'h0000_0000, "sw_pre");
        bus.SRAM_WE_N = 1'b1;
        bus.SRAM_OE_N = 1'b1;
        tb_drv        = 1'b0;
        tick(1);
        chk("sw_e0_viol", viol, 0);
        bus.SRAM_WE_N = 1'b0;
        tb_drv        = 1'b1;
        tb_dq         = 32'hBAD0_BAD0;
        tick(1);
        chk("sw_e1_viol", viol, 0);
        start_read(17'h0_0200, 32'h0000_0000);
        tick(1);
        chk("sw_viol", viol, 1);
        chk("sw_no_commit", wr_commit, 0);
        wait_read("sw_rd", 2);

        // Reset on the would-be commit edge drops the write
        write_word(17'h0_0400, 32'hCAFE_F00D, "rm_pre");
        bus.SRAM_WE_N = 1'b1;
        tb_drv        = 1'b0;
        tick(1);
        bus.SRAM_WE_N = 1'b0;
        tb_drv        = 1'b1;
        tb_dq         = 32'h0BAD_0BAD;
        tick(2);
        chk("rm_pre_viol", viol, 1);
        rst = 1'b0;
        tick(1);
        chk("rm_rd_valid", rd_valid, 0);
        chk("rm_wr_commit", wr_commit, 0);
        chk("rm_viol", viol, 0);
        chk("rm_dq_free", dq, 32'h0BAD_0BAD);
        rst = 1'b1;
        start_read(17'h0_0400, 32'hCAFE_F00D);
        wait_read("rm_rd", 3);

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
